alu_muldiv: RTL and testbench

- Registered, handshaked execute unit for the RISC-V core.
- Covers the base integer ALU operations, including shifts and unsigned compare, plus the RV32M multiply/divide family.
- Single-cycle ops complete in one cycle; multiply and divide run iteratively over DATA_WIDTH cycles.
- Sits between decode/issue and writeback; valid/ready on both sides lets the pipeline stall on long ops.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/muldiv_iter.sv | 126 ++++++++++++
 rtl/alu_muldiv.sv | 127 ++++++++++++
 tb/tb_alu_muldiv.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute unit: operation encoding, FSM states and
// the decode helper that separates single-cycle from iterative operations.
// Imported by alu_muldiv and muldiv_iter.
package alu_pkg;

   typedef enum logic [4:0] {
      ADD    = 5'd0,
      SUB    = 5'd1,
      AND    = 5'd2,
      OR     = 5'd3,
      XOR    = 5'd4,
      SLT    = 5'd5,
      SLTU   = 5'd6,
      SLL    = 5'd7,
      SRL    = 5'd8,
      SRA    = 5'd9,
      PASSB  = 5'd10,
      MUL    = 5'd16,
      MULH   = 5'd17,
      MULHSU = 5'd18,
      MULHU  = 5'd19,
      DIV    = 5'd20,
      DIVU   = 5'd21,
      REM    = 5'd22,
      REMU   = 5'd23
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // All multiply/divide encodings live in the upper half of the opcode space.
   function automatic logic is_iterative(input alu_op_t op);
      return op[4];
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle.
// Latency: start_i loads operands, done_o pulses on the W-th step with result_o valid.
// Ports: clk, rst_n, start_i/op_i/a_i/b_i (load), done_o/result_o (completion, one cycle).
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  alu_op_t       op_i,
   input  logic [W-1:0]  a_i,
   input  logic [W-1:0]  b_i,
   output logic          done_o,
   output logic [W-1:0]  result_o
);

   localparam int CW = $clog2(W);

   logic          busy_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  acc_q, acc_d;   // product high half / partial remainder
   logic [W-1:0]  sh_q, sh_d;     // multiplier (shifts out) / dividend->quotient
   logic [W-1:0]  opd_q;          // multiplicand / divisor magnitude
   logic          is_div_q;
   logic          lo_q;           // MUL: low half; REM/REMU: remainder
   logic          neg_q;          // negate the selected result at the end
   logic          bzero_q;        // divide by zero: quotient forced to all-ones

   // Operand sign handling at load time.
   logic          a_signed, b_signed, a_neg, b_neg;
   logic [W-1:0]  a_mag, b_mag;
   logic          op_div, op_lo;

   always_comb begin
      a_signed = (op_i == MUL) || (op_i == MULH) || (op_i == MULHSU) ||
                 (op_i == DIV) || (op_i == REM);
      b_signed = (op_i == MUL) || (op_i == MULH) || (op_i == DIV) || (op_i == REM);
      a_neg    = a_signed && a_i[W-1];
      b_neg    = b_signed && b_i[W-1];
      a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
      b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
      op_div   = (op_i == DIV) || (op_i == DIVU) || (op_i == REM) || (op_i == REMU);
      op_lo    = (op_i == MUL) || (op_i == REM) || (op_i == REMU);
   end

   // One iteration step.
   logic [W:0] sum, rem_sh, diff;

   always_comb begin
      acc_d  = acc_q;
      sh_d   = sh_q;
      sum    = '0;
      rem_sh = '0;
      diff   = '0;
      if (is_div_q) begin
         // Restoring divide: shift next dividend bit in, trial-subtract divisor.
         rem_sh = {acc_q, sh_q[W-1]};
         diff   = rem_sh - {1'b0, opd_q};
         if (!diff[W]) begin
            acc_d = diff[W-1:0];
            sh_d  = {sh_q[W-2:0], 1'b1};
         end else begin
            acc_d = rem_sh[W-1:0];
            sh_d  = {sh_q[W-2:0], 1'b0};
         end
      end else begin
         // Shift-add multiply: add on multiplier LSB, shift {carry,acc,sh} right.
         sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});
         acc_d = sum[W:1];
         sh_d  = {sum[0], sh_q[W-1:1]};
      end
   end

   // Result is formed from the step being taken, so it is ready on the done cycle.
   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0]   quo, rem;

   always_comb begin
      prod     = {acc_d, sh_d};
      prod_fix = neg_q ? (~prod + 1'b1) : prod;
      quo      = bzero_q ? {W{1'b1}} : (neg_q ? (~sh_d + 1'b1) : sh_d);
      rem      = neg_q ? (~acc_d + 1'b1) : acc_d;
      if (is_div_q) begin
         result_o = lo_q ? rem : quo;
      end else begin
         result_o = lo_q ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
      end
   end

   assign done_o = busy_q && (cnt_q == CW'(W-1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         sh_q     <= '0;
         opd_q    <= '0;
         is_div_q <= 1'b0;
         lo_q     <= 1'b0;
         neg_q    <= 1'b0;
         bzero_q  <= 1'b0;
      end else if (start_i) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         acc_q    <= '0;
         sh_q     <= a_mag;
         opd_q    <= b_mag;
         is_div_q <= op_div;
         lo_q     <= op_lo;
         // Remainder takes the dividend's sign; everything else the product of signs.
         neg_q    <= (op_i == REM) ? a_neg : (a_neg ^ b_neg);
         bzero_q  <= op_div && !op_lo && (b_i == '0);
      end else if (busy_q) begin
         acc_q <= acc_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_q + CW'(1);
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked execute unit: base integer ALU (1 cycle) plus RV32M mul/div (DATA_WIDTH cycles).
// Latency: single-cycle ops 1, iterative ops DATA_WIDTH+1; one op in flight, no re-accept in DONE.
// Ports: InValid/InReady + A/B/ALUCtl in; OutValid/OutReady + Result/Zero out; Busy during iteration.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [4:0]            ALUCtl,
   output logic                  OutValid,
   input  logic                  OutReady,
   output logic [DATA_WIDTH-1:0] Result,
   output logic                  Zero,
   output logic                  Busy
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;

   alu_op_t               op;
   logic                  iter_op;
   logic                  accept;
   logic                  mdu_start;
   logic                  mdu_done;
   logic [DATA_WIDTH-1:0] mdu_result;
   logic [SHAMT_W-1:0]    shamt;
   logic [DATA_WIDTH-1:0] alu_res;

   assign op      = alu_op_t'(ALUCtl);
   // Opcodes 24..31 also have bit 4 set but are undefined; they stay single-cycle.
   assign iter_op = is_iterative(op) && !ALUCtl[3];
   assign accept  = InValid && (state_q == ST_IDLE);
   assign shamt   = B[SHAMT_W-1:0];

   // Single-cycle datapath; undefined encodings give zero.
   always_comb begin
      alu_res = '0;
      case (op)
         ADD:     alu_res = A + B;
         SUB:     alu_res = A - B;
         AND:     alu_res = A & B;
         OR:      alu_res = A | B;
         XOR:     alu_res = A ^ B;
         SLT:     alu_res[0] = ($signed(A) < $signed(B));
         SLTU:    alu_res[0] = (A < B);
         SLL:     alu_res = A << shamt;
         SRL:     alu_res = A >> shamt;
         SRA:     alu_res = $unsigned($signed(A) >>> shamt);
         PASSB:   alu_res = B;
         default: alu_res = '0;
      endcase
   end

   muldiv_iter #(
      .W (DATA_WIDTH)
   ) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mdu_start),
      .op_i     (op),
      .a_i      (A),
      .b_i      (B),
      .done_o   (mdu_done),
      .result_o (mdu_result)
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      mdu_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (iter_op) begin
                  mdu_start = 1'b1;
                  state_d   = ST_BUSY;
               end else begin
                  result_d = alu_res;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            if (mdu_done) begin
               result_d = mdu_result;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (OutReady) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Zero tracks the value being registered, not the output port.
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign InReady  = (state_q == ST_IDLE);
   assign OutValid = (state_q == ST_DONE);
   assign Busy     = (state_q == ST_BUSY);
   assign Result   = result_q;
   assign Zero     = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: hand-computed vectors, latency and handshake checks.
module tb_alu_muldiv;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        InValid;
   logic        InReady;
   logic [31:0] A;
   logic [31:0] B;
   logic [4:0]  ALUCtl;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] Result;
   logic        Zero;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   alu_muldiv #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .InValid  (InValid),
      .InReady  (InReady),
      .A        (A),
      .B        (B),
      .ALUCtl   (ALUCtl),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Result   (Result),
      .Zero     (Zero),
      .Busy     (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge in IDLE; return at the negedge where OutValid is seen.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
      A = a; B = b; ALUCtl = op; InValid = 1'b1;
      @(negedge clk);
      InValid = 1'b0;
      A = $urandom; B = $urandom; ALUCtl = 5'(op + 5'd1);   // captured values must hold
      lat = 1;
      busy_n = 0;
      while (!OutValid && lat < 100) begin
         if (Busy) busy_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic exec(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat, busy_n;
      run_op(op, a, b, lat, busy_n);
      chk({tag, " result"}, Result, exp);
      chk({tag, " zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " busy cycles"}, 32'(busy_n), (exp_lat == 1) ? 32'd0 : 32'd32);
      @(negedge clk);
   endtask

   initial begin
      int lat, busy_n, ov_seen;
      rst_n = 1'b0; InValid = 1'b0; A = '0; B = '0; ALUCtl = '0; OutReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset Result", Result, 32'h0);
      chk("reset Zero", {31'd0, Zero}, 32'd1);
      chk("reset OutValid", {31'd0, OutValid}, 32'd0);
      chk("reset Busy", {31'd0, Busy}, 32'd0);
      chk("reset InReady", {31'd0, InReady}, 32'd1);

      exec("ADD ovf",   ADD,    32'h7FFFFFFF, 32'h1,        32'h80000000, 1);
      exec("SUB 5-5",   SUB,    32'd5,        32'd5,        32'h0,        1);
      exec("SLT",       SLT,    32'hFFFFFFFF, 32'h1,        32'h1,        1);
      exec("SLTU",      SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        1);
      exec("SRA",       SRA,    32'h80000000, 32'h21,       32'hC0000000, 1);
      exec("SLL",       SLL,    32'h1,        32'h25,       32'h20,       1);
      exec("SRL",       SRL,    32'h80000000, 32'd31,       32'h1,        1);
      exec("XOR",       XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
      exec("PASSB",     PASSB,  32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 1);
      exec("undef 11",  5'd11,  32'h5,        32'h6,        32'h0,        1);
      exec("undef 24",  5'd24,  32'h5,        32'h6,        32'h0,        1);
      exec("MULH",      MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        33);
      exec("MULHU",     MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      exec("MULHSU",    MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      exec("MUL",       MUL,    32'd6,        32'hFFFFFFFD, 32'hFFFFFFEE, 33);
      exec("DIV -7/2",  DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      exec("REM -7%2",  REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      exec("DIVU /0",   DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, 33);
      exec("REMU /0",   REMU,   32'd7,        32'd0,        32'd7,        33);
      exec("DIV /0",    DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 33);
      exec("DIV ovf",   DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
      exec("REM ovf",   REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        33);
      exec("DIVU",      DIVU,   32'd100,      32'd7,        32'd14,       33);

      // Backpressure: result held in DONE, input pulse ignored.
      OutReady = 1'b0;
      run_op(ADD, 32'd2, 32'd2, lat, busy_n);
      chk("bp latency", 32'(lat), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            A = 32'd9; B = 32'd9; ALUCtl = SUB; InValid = 1'b1;
         end else begin
            InValid = 1'b0;
         end
         @(negedge clk);
         chk("bp Result hold", Result, 32'd4);
         chk("bp OutValid hold", {31'd0, OutValid}, 32'd1);
         chk("bp InReady low", {31'd0, InReady}, 32'd0);
      end
      InValid = 1'b0;
      OutReady = 1'b1;
      @(negedge clk);
      chk("bp release InReady", {31'd0, InReady}, 32'd1);
      chk("bp release OutValid", {31'd0, OutValid}, 32'd0);
      @(negedge clk);
      chk("bp pulse dropped", {31'd0, OutValid | Busy}, 32'd0);

      // Reset during a divide aborts it.
      A = 32'd100; B = 32'd7; ALUCtl = DIVU; InValid = 1'b1;
      @(negedge clk);
      InValid = 1'b0;
      for (int i = 1; i < 12; i++) @(negedge clk);
      chk("abort in BUSY", {31'd0, Busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort Busy", {31'd0, Busy}, 32'd0);
      chk("abort Result", Result, 32'd0);
      ov_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (OutValid || Busy) ov_seen++;
         @(negedge clk);
      end
      chk("abort no OutValid", 32'(ov_seen), 32'd0);
      exec("ADD after abort", ADD, 32'd2, 32'd3, 32'd5, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
